// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle between the multicycle controller and its datapath.
// The master modport is the controller; the slave modport is the datapath side.
interface multicycle_ctrl_if;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic        zero;
    logic        mem_ready;

    logic        pc_write;
    logic        adr_src;
    logic        ir_write;
    logic        mem_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic [1:0]  imm_src;
    logic [2:0]  alu_control;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] instret;

    modport master (
        input  op, funct3, funct7, zero, mem_ready,
        output pc_write, adr_src, ir_write, mem_write, reg_write,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control,
               illegal, state, instret
    );

    modport slave (
        output op, funct3, funct7, zero, mem_ready,
        input  pc_write, adr_src, ir_write, mem_write, reg_write,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control,
               illegal, state, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset controller: FSM sequencing fetch/decode/execute with
// memory-ready stalls, ALU decode and a retired-instruction counter.
module multicycle_ctrl (
    input  logic            clk,
    input  logic            rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ALUI = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instret;

    logic        w_pc_write;
    logic        w_adr_src;
    logic        w_ir_write;
    logic        w_mem_write;
    logic        w_reg_write;
    logic [1:0]  w_alu_src_a;
    logic [1:0]  w_alu_src_b;
    logic [1:0]  w_result_src;
    logic [1:0]  w_imm_src;
    logic [2:0]  w_alu_control;
    logic        w_illegal;
    logic [2:0]  w_alu_dec;
    logic        w_retire;

    always_comb begin
        w_alu_dec = 3'b000;
        case (bus.funct3)
            3'b000:  w_alu_dec = (bus.op[5] & bus.funct7) ? 3'b001 : 3'b000;
            3'b010:  w_alu_dec = 3'b101;
            3'b110:  w_alu_dec = 3'b011;
            3'b111:  w_alu_dec = 3'b010;
            default: w_alu_dec = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_pc_write    = 1'b0;
        w_adr_src     = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_result_src  = 2'b00;
        w_imm_src     = 2'b00;
        w_alu_control = 3'b000;
        w_illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = bus.mem_ready;
                w_pc_write   = bus.mem_ready;
                if (bus.mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (bus.op)
                    OP_LW:   begin w_imm_src = 2'b00; w_next = S_MEMADR; end
                    OP_SW:   begin w_imm_src = 2'b01; w_next = S_MEMADR; end
                    OP_R:    begin w_imm_src = 2'b00; w_next = S_EXECR;  end
                    OP_ALUI: begin w_imm_src = 2'b00; w_next = S_EXECI;  end
                    OP_JAL:  begin w_imm_src = 2'b11; w_next = S_JAL;    end
                    OP_BEQ:  begin w_imm_src = 2'b10; w_next = S_BEQ;    end
                    default: begin w_illegal = 1'b1;  w_next = S_FETCH;  end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_imm_src   = bus.op[5] ? 2'b01 : 2'b00;
                w_next      = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                if (bus.mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (bus.mem_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b00;
                w_alu_control = w_alu_dec;
                w_next        = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b01;
                w_alu_control = w_alu_dec;
                w_next        = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_write  = 1'b1;
                w_next      = S_ALUWB;
            end
            S_BEQ: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b00;
                w_alu_control = 3'b001;
                w_imm_src     = 2'b10;
                w_pc_write    = bus.zero;
                w_next        = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Illegal-opcode returns come from DECODE, so they never retire.
    assign w_retire = (w_next == S_FETCH) &&
                      ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                       (r_state == S_ALUWB) || (r_state == S_BEQ));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= 32'd0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    // Strobes are gated by rst_n so FETCH's mem_ready path stays quiet in reset.
    assign bus.pc_write    = w_pc_write  & rst_n;
    assign bus.ir_write    = w_ir_write  & rst_n;
    assign bus.mem_write   = w_mem_write & rst_n;
    assign bus.reg_write   = w_reg_write & rst_n;
    assign bus.illegal     = w_illegal   & rst_n;
    assign bus.adr_src     = w_adr_src;
    assign bus.alu_src_a   = w_alu_src_a;
    assign bus.alu_src_b   = w_alu_src_b;
    assign bus.result_src  = w_result_src;
    assign bus.imm_src     = w_imm_src;
    assign bus.alu_control = w_alu_control;
    assign bus.state       = r_state;
    assign bus.instret     = r_instret;
endmodule
